alu_flag_capture: RTL
=====================

// Module: alu_flag_capture
// PURPOSE
//   Downstream stage of the n-bit ALU. Accepts each ALU result (W data bits plus carry/borrow MSB)
//   and its 3-bit op code over a valid/ready handshake, derives N/Z/C/SUB flags, and buffers
//   result+flags in a small FIFO toward the writeback/consumer side.
//   Also keeps a saturating count of carry/borrow events for debug and performance visibility.
// PARAMETERS
//   W      32  ALU data width; in_result is W+1 bits wide
//   DEPTH  2   FIFO entries; power of 2, >=2
//   CNT_W  16  width of the carry-event counter
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      upstream ALU result valid
//   in_ready   out  1      stage can accept (FIFO not full)
//   in_result  in   W+1    [W]=carry-out (borrow when op==3'b101), [W-1:0]=data
//   in_alop    in   3      ALU op code that produced in_result
//   out_valid  out  1      FIFO head valid
//   out_ready  in   1      consumer accepts head
//   out_data   out  W      head data
//   out_flags  out  4      head flags {SUB,C,N,Z}
//   clr_cnt    in   1      synchronous clear of carry_cnt
//   carry_cnt  out  CNT_W  saturating count of accepted entries with C=1
// BEHAVIOUR
//   Reset (async assert, sync-release usage): FIFO empty, pointers 0, out_valid=0, out_data=0,
//     out_flags=0, carry_cnt=0, in_ready=1 after reset.
//   Flags computed combinationally at input, stored with data:
//     Z = (in_result[W-1:0]==0); N = in_result[W-1]; C = in_result[W]; SUB = (in_alop==3'b101).
//     C is stored as received (already a borrow for SUB); no re-inversion.
//   Accept: in_valid & in_ready at edge k. Pop: out_valid & out_ready at edge k.
//   in_ready = !full, registered view of occupancy; no same-cycle bypass when full.
//   Latency: entry accepted into an empty FIFO at edge k appears on out_* after edge k (1 cycle).
//   Ordering is strictly FIFO; out_data/out_flags hold stable while out_valid & !out_ready.
//   Simultaneous push+pop: allowed when not full; occupancy unchanged; allowed when full only
//     if in_ready was already 1 (i.e., never -- full blocks push regardless of pop).
//   Pointers are log2(DEPTH) bits plus a wrap bit; full = ptr MSBs differ and LSBs equal.
//   Pop from empty and push to full are impossible by construction (qualified by valid/ready).
//   When empty, out_data/out_flags = 0 (not stale head).
//   carry_cnt: +1 on every accepted entry with C=1; saturates at all-ones; clr_cnt wins over
//     a same-cycle increment (result 0).
//   Reset mid-operation: all buffered entries discarded, counter cleared immediately.
//   X-safety: in_result/in_alop ignored when in_valid=0.
// STRUCTURE
//   Shared package alu_pkg: ALOP_SUB=3'b101 and other ALU op codes; flag index localparams
//     FLG_Z=0, FLG_N=1, FLG_C=2, FLG_SUB=3; flag-vector width 4.
//   Sub-module alu_res_fifo: generic sync FIFO (width W+4, DEPTH) with push/pop, full/empty.
//   Top: flag derivation, handshake glue, counter.
// TESTING
//   1 Reset then push result=33'h0_0000_0000, op=3'b010 -> next cycle out_valid=1, data=0,
//     flags=4'b0001 (Z).
//   2 Push 33'h1_8000_0000, op=3'b101 -> flags=4'b1110 (SUB,C,N), carry_cnt=1.
//   3 Hold out_ready=0, push DEPTH=2 entries -> in_ready=0 after 2nd accept; 3rd in_valid held;
//     data stable.
//   4 Full FIFO, out_ready=1, in_valid=1 -> pop order A,B then C accepted; no loss or duplication.
//   5 CNT_W=2 build: 5 carry entries -> carry_cnt stays 3; clr_cnt with carry push same cycle -> 0.
//   6 Assert rst_n=0 with 2 entries queued -> out_valid=0, carry_cnt=0 immediately (async),
//     in_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes and flag-vector layout used by the result capture stage.
package alu_pkg;

  localparam logic [2:0] ALOP_AND = 3'b000;
  localparam logic [2:0] ALOP_OR  = 3'b001;
  localparam logic [2:0] ALOP_ADD = 3'b010;
  localparam logic [2:0] ALOP_XOR = 3'b011;
  localparam logic [2:0] ALOP_SLT = 3'b100;
  localparam logic [2:0] ALOP_SUB = 3'b101;
  localparam logic [2:0] ALOP_SLL = 3'b110;
  localparam logic [2:0] ALOP_SRL = 3'b111;

  localparam int unsigned FLG_Z   = 0;
  localparam int unsigned FLG_N   = 1;
  localparam int unsigned FLG_C   = 2;
  localparam int unsigned FLG_SUB = 3;
  localparam int unsigned FLG_W   = 4;

endpackage

// File: rtl/alu_flag_capture_if.sv
// Result handshake bundle between the ALU, the flag capture stage and its consumer.
interface alu_flag_capture_if #(
  parameter int unsigned W = 32
) ();
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [W:0]       in_result;
  logic [2:0]       in_alop;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [FLG_W-1:0] out_flags;

  modport master (
    output in_valid, in_result, in_alop, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_result, in_alop, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );

endinterface

// File: rtl/alu_res_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; read data is forced to zero while empty.
module alu_res_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PtrOne;
      if (i_pop)  r_rptr <= r_rptr + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  // Zero while empty so the consumer never sees a stale head.
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/alu_flag_capture.sv
// ALU result capture: derives N/Z/C/SUB flags, buffers result+flags, counts carry events.
module alu_flag_capture
  import alu_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_flag_capture_if.slave  bus,
  input  logic               clr_cnt,
  output logic [CNT_W-1:0]   carry_cnt
);

  logic [FLG_W-1:0]   w_flags;
  logic [W+FLG_W-1:0] w_wdata;
  logic [W+FLG_W-1:0] w_rdata;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  // C is stored exactly as the ALU produced it; for SUB it is already a borrow.
  always_comb begin
    w_flags          = '0;
    w_flags[FLG_Z]   = (bus.in_result[W-1:0] == '0);
    w_flags[FLG_N]   = bus.in_result[W-1];
    w_flags[FLG_C]   = bus.in_result[W];
    w_flags[FLG_SUB] = (bus.in_alop == ALOP_SUB);
  end

  assign w_wdata = {w_flags, bus.in_result[W-1:0]};
  assign w_push  = bus.in_valid & ~w_full;
  assign w_pop   = ~w_empty & bus.out_ready;

  alu_res_fifo #(
    .WIDTH (W + FLG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  assign bus.out_data  = w_rdata[W-1:0];
  assign bus.out_flags = w_rdata[W+FLG_W-1:W];

  // Clear beats a same-cycle increment; the counter sticks at all-ones.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr_cnt) begin
      w_cnt_nxt = '0;
    end else if (w_push && w_flags[FLG_C] && (r_cnt != '1)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= w_cnt_nxt;
  end

  assign carry_cnt = r_cnt;

endmodule
